// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and instruction-fetch sequencer with safe in-flight redirect handling
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic [31:0] PC,
  input  logic [31:0] PC_Plus4,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  input  logic        Jmp,
  input  logic [31:0] Jmp_Target,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Inst,
  output logic [31:0] Inst_PC,
  output logic        Inst_Valid,
  input  logic        Inst_Ready
);
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] pend, pc_nx, pend_nx, inst_nx, inst_pc_nx, tgt_raw, target;
  logic redirect;
  assign redirect = Jmp | Br_Taken;
  assign tgt_raw = Jmp ? Jmp_Target : Br_Target;
  assign target = tgt_raw & ~32'h3;
  assign IMem_Req = (state == FETCH) || (state == DISCARD);
  assign IMem_Addr = PC;
  assign Inst_Valid = state == HOLD;
  always_comb begin
    state_nx = state;
    pc_nx = PC;
    pend_nx = pend;
    inst_nx = Inst;
    inst_pc_nx = Inst_PC;
    case (state)
      IDLE: begin
        state_nx = FETCH;
        pc_nx = redirect ? target : PC;
      end
      FETCH: begin
        if (IMem_Ack && redirect) pc_nx = target;
        else if (IMem_Ack) begin
          inst_nx = IMem_Data;
          inst_pc_nx = PC;
          pc_nx = PC_Plus4;
          state_nx = HOLD;
        end else if (redirect) begin
          pend_nx = target;
          state_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (IMem_Ack) begin
          pc_nx = redirect ? target : pend;
          state_nx = FETCH;
        end else pend_nx = redirect ? target : pend;
      end
      HOLD: begin
        pc_nx = redirect ? target : PC;
        if (redirect || Inst_Ready) state_nx = FETCH;
      end
    endcase
  end
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= IDLE;
      PC <= RESET_PC;
      pend <= '0;
      Inst <= '0;
      Inst_PC <= '0;
    end else begin
      state <= state_nx;
      PC <= pc_nx;
      pend <= pend_nx;
      Inst <= inst_nx;
      Inst_PC <= inst_pc_nx;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a program-order model
module tb_pc_fetch_unit;
  logic Clk = 1'b0, Clrn = 1'b0;
  logic [31:0] PC, PC_Plus4, Br_Target = '0, Jmp_Target = '0, IMem_Addr, IMem_Data = '0, Inst, Inst_PC;
  logic Br_Taken = 1'b0, Jmp = 1'b0, IMem_Req, IMem_Ack = 1'b0, Inst_Valid, Inst_Ready = 1'b0;
  int passed = 0, failed = 0, total = 0, delivered = 0;
  logic [31:0] exp_next = '0, req_addr = '0;
  logic req_open = 1'b0, model_on = 1'b0;
  pc_fetch_unit #(.RESET_PC(32'h0)) dut (
    .Clk(Clk), .Clrn(Clrn), .PC(PC), .PC_Plus4(PC_Plus4),
    .Br_Taken(Br_Taken), .Br_Target(Br_Target), .Jmp(Jmp), .Jmp_Target(Jmp_Target),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data),
    .Inst(Inst), .Inst_PC(Inst_PC), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready)
  );
  always #5 Clk = ~Clk;
  assign PC_Plus4 = PC + 32'd4;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic ack(input logic a);
    IMem_Ack = a;
    IMem_Data = a ? mem_word(IMem_Addr) : $urandom;
  endtask
  task automatic tick();
    if (model_on) begin
      if (Inst_Valid) begin
        chk("inst_pc", Inst_PC, exp_next);
        chk("inst", Inst, mem_word(Inst_PC));
      end
      if (req_open) chk("addr_hold", IMem_Addr, req_addr);
      req_open = IMem_Req && !IMem_Ack;
      req_addr = IMem_Addr;
      if (Jmp || Br_Taken) exp_next = (Jmp ? Jmp_Target : Br_Target) & ~32'h3;
      else if (Inst_Valid && Inst_Ready) begin
        exp_next += 32'd4;
        delivered++;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic restart();
    exp_next = '0;
    req_open = 1'b0;
    Clrn = 1'b1;
    model_on = 1'b1;
  endtask
  initial begin
    int r;
    repeat (3) @(negedge Clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", 32'(IMem_Req), 32'd0);
    chk("rst_valid", 32'(Inst_Valid), 32'd0);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_inst_pc", Inst_PC, 32'h0);
    restart();
    chk("idle_req", 32'(IMem_Req), 32'd0);
    tick();
    chk("first_req", 32'(IMem_Req), 32'd1);
    chk("first_addr", IMem_Addr, 32'h0);
    Inst_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ack(IMem_Req);
      chk("valid_pat", 32'(Inst_Valid), 32'(i % 2));
      if (i % 2 == 1) chk("seq_pc", Inst_PC, 32'((i / 2) * 4));
      tick();
    end
    chk("seq_next_pc", PC, 32'h10);
    for (int i = 0; i < 4; i++) begin
      ack(i == 3);
      chk("ws_addr", IMem_Addr, 32'h10);
      chk("ws_req", 32'(IMem_Req), 32'd1);
      tick();
    end
    ack(1'b0);
    chk("ws_valid", 32'(Inst_Valid), 32'd1);
    chk("ws_inst", Inst, mem_word(32'h10));
    chk("ws_inst_pc", Inst_PC, 32'h10);
    chk("ws_next_pc", PC, 32'h14);
    Inst_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(Inst_Valid), 32'd1);
      chk("bp_inst_pc", Inst_PC, 32'h10);
      chk("bp_inst", Inst, mem_word(32'h10));
      chk("bp_req", 32'(IMem_Req), 32'd0);
      tick();
    end
    Inst_Ready = 1'b1;
    Jmp = 1'b1;
    Jmp_Target = 32'h40;
    tick();
    Jmp = 1'b0;
    chk("flush_valid", 32'(Inst_Valid), 32'd0);
    chk("flush_req", 32'(IMem_Req), 32'd1);
    chk("flush_addr", IMem_Addr, 32'h40);
    ack(1'b1);
    Jmp = 1'b1;
    Jmp_Target = 32'h20;
    tick();
    Jmp = 1'b0;
    ack(1'b0);
    chk("ackredir_valid", 32'(Inst_Valid), 32'd0);
    chk("ackredir_addr", IMem_Addr, 32'h20);
    Br_Taken = 1'b1;
    Br_Target = 32'h100;
    tick();
    Br_Taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("dis_addr", IMem_Addr, 32'h20);
      chk("dis_req", 32'(IMem_Req), 32'd1);
      chk("dis_valid", 32'(Inst_Valid), 32'd0);
      if (i == 1) ack(1'b1);
      tick();
    end
    ack(1'b0);
    chk("dis_new_addr", IMem_Addr, 32'h100);
    chk("dis_new_valid", 32'(Inst_Valid), 32'd0);
    Jmp = 1'b1;
    Jmp_Target = 32'h200;
    Br_Taken = 1'b1;
    Br_Target = 32'h300;
    tick();
    Jmp = 1'b0;
    Br_Taken = 1'b0;
    chk("prio_hold_addr", IMem_Addr, 32'h100);
    ack(1'b1);
    tick();
    ack(1'b0);
    chk("prio_addr", IMem_Addr, 32'h200);
    chk("prio_valid", 32'(Inst_Valid), 32'd0);
    ack(1'b1);
    Br_Taken = 1'b1;
    Br_Target = 32'h103;
    tick();
    Br_Taken = 1'b0;
    chk("align_addr", IMem_Addr, 32'h100);
    Jmp = 1'b1;
    Jmp_Target = 32'hFFFF_FFFC;
    tick();
    Jmp = 1'b0;
    ack(1'b1);
    tick();
    ack(1'b0);
    chk("wrap_valid", 32'(Inst_Valid), 32'd1);
    chk("wrap_inst_pc", Inst_PC, 32'hFFFF_FFFC);
    chk("wrap_pc", PC, 32'h0);
    tick();
    chk("wrap_addr", IMem_Addr, 32'h0);
    Br_Taken = 1'b1;
    Br_Target = 32'h500;
    tick();
    Br_Taken = 1'b0;
    chk("ar_pre_req", 32'(IMem_Req), 32'd1);
    #2;
    model_on = 1'b0;
    Clrn = 1'b0;
    #1;
    chk("ar_req", 32'(IMem_Req), 32'd0);
    chk("ar_pc", PC, 32'h0);
    chk("ar_valid", 32'(Inst_Valid), 32'd0);
    chk("ar_inst", Inst, 32'h0);
    chk("ar_inst_pc", Inst_PC, 32'h0);
    IMem_Ack = 1'b1;
    IMem_Data = 32'hDEAD_BEEF;
    @(negedge Clk);
    chk("ar_ack_valid", 32'(Inst_Valid), 32'd0);
    @(negedge Clk);
    restart();
    chk("ar_idle_req", 32'(IMem_Req), 32'd0);
    chk("ar_idle_valid", 32'(Inst_Valid), 32'd0);
    tick();
    chk("ar_fetch_req", 32'(IMem_Req), 32'd1);
    chk("ar_fetch_addr", IMem_Addr, 32'h0);
    chk("ar_fetch_valid", 32'(Inst_Valid), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      ack(IMem_Req && ($urandom_range(0, 1) == 1));
      Inst_Ready = $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 19);
      Jmp = r == 0;
      Br_Taken = r <= 2;
      Jmp_Target = $urandom;
      Br_Target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick();
    end
    chk("liveness", 32'(delivered > 200), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the CPU front end. Holds the current PC, drives it to the external PC+4 adder and the instruction memory, and selects the next PC from the adder result, a branch target or a jump target. Runs a request/acknowledge handshake with instruction memory and hands each fetched word to decode through a valid/ready pair. Redirects that arrive while a fetch is in flight are handled safely.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- Clk  in  1  rising-edge clock
- Clrn  in  1  asynchronous active-low reset
- PC  out  32  current fetch PC; feeds the +4 adder input
- PC_Plus4  in  32  combinational PC+4 from the adder (same cycle as PC)
- Br_Taken  in  1  branch redirect request, sampled each rising edge
- Br_Target  in  32  branch target
- Jmp  in  1  jump redirect request; has priority over Br_Taken
- Jmp_Target  in  32  jump target
- IMem_Req  out  1  fetch request
- IMem_Addr  out  32  fetch address; stable while IMem_Req=1
- IMem_Ack  in  1  one-cycle acknowledge; IMem_Data valid in the same cycle
- IMem_Data  in  32  fetched instruction word
- Inst  out  32  instruction to decode
- Inst_PC  out  32  address of Inst
- Inst_Valid  out  1  Inst/Inst_PC valid
- Inst_Ready  in  1  decode accepts Inst

## Operation

- Redirect = Jmp | Br_Taken.
- Target = Jmp ? Jmp_Target : Br_Target, with bits [1:0] forced to 0.
- IMem_Addr = PC in every state except DISCARD, where it is the held in-flight address.
- Next-PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

States:
- IDLE: entered on reset. IMem_Req=0, Inst_Valid=0. Next state is FETCH unconditionally. A Redirect here loads PC←Target.
- FETCH: IMem_Req=1.
  - Ack with no Redirect: Inst←IMem_Data, Inst_PC←PC, PC←PC_Plus4, go to HOLD.
  - Ack with Redirect: drop the data, PC←Target, stay in FETCH.
  - No Ack with Redirect: Pend←Target, go to DISCARD. The request is not withdrawn.
  - No Ack, no Redirect: stay in FETCH.
- DISCARD: IMem_Req=1, address held at the old PC. Each further Redirect overwrites Pend (the latest one wins). On Ack: drop the data, PC←(Redirect ? Target : Pend), go to FETCH.
- HOLD: Inst_Valid=1.
  - Redirect: drop Inst (Inst_Valid=0 next cycle), PC←Target, go to FETCH. Redirect takes priority over Inst_Ready.
  - Inst_Ready with no Redirect: go to FETCH.
  - Otherwise: hold Inst, Inst_PC and PC unchanged.
- A dropped or discarded word never appears with Inst_Valid=1.

## Timing

- Reset (Clrn=0, asynchronous): PC=RESET_PC, state=IDLE, IMem_Req=0, Inst_Valid=0, Inst=0, Inst_PC=0, Pend=0.
- First IMem_Req=1 is in the 2nd cycle after Clrn rises (IDLE lasts one cycle).
- Latency with a zero-wait memory (Ack in the same cycle as Req): Inst_Valid rises 1 cycle after the Req cycle.
- Sustained throughput is 1 instruction per 2 cycles (FETCH, HOLD) with zero-wait memory and Inst_Ready=1.
- All outputs are registered or state-decoded. Nothing combinational passes from IMem_Ack or Inst_Ready to IMem_Req or Inst_Valid.
- Reset asserted mid-fetch abandons the request immediately. An Ack arriving during or after reset is ignored.

## Test plan

- Reset sequencing: hold Clrn=0 with RESET_PC=0, then release. Required: IDLE for 1 cycle, then IMem_Req=1 with IMem_Addr=0. With Ack every cycle and Inst_Ready=1, Inst_PC follows 0, 4, 8, 0xC, each valid for exactly 1 cycle.
- Wait states: Ack delayed 3 cycles at PC=0x10. Required: IMem_Addr stays 0x10 for all 4 cycles, Inst=IMem_Data, Inst_PC=0x10, next PC=0x14.
- Redirect in flight: Br_Taken with Br_Target=0x100 while fetch of 0x20 is pending, Ack 2 cycles later. Required: the word for 0x20 is never valid, the next request is to 0x100. Add a Jmp to 0x200 and a Br_Taken to 0x300 in the same cycle; required next fetch is 0x200.
- Backpressure and flush: Inst_Ready=0 for 5 cycles in HOLD. Required: Inst and Inst_PC stable, no new IMem_Req. Then Jmp to 0x40. Required: Inst_Valid falls and the next fetch is 0x40.
- Wrap and alignment: PC=0xFFFF_FFFC fetched. Required: next PC=0x0000_0000. Br_Target=0x103 is taken as 0x100.
- Async reset mid-fetch: Clrn pulled low between clock edges during DISCARD. Required: outputs go to reset values immediately, and a later Ack produces no Inst_Valid.
